reg_pipe_n: RTL and testbench
=============================

Name: reg_pipe_n

Overview:
- Parametrised successor to the basic N-bit enabled register: a DEPTH-stage, N-bit-wide pipeline register chain with a valid/ready handshake on both sides.
- Adds per-stage valid tracking, backpressure, bubble collapse and an occupancy count.
- Sits between datapath blocks, e.g. Morse symbol decoder to character buffer, where consumer stalls must not drop data.

Parameters:
- N, 32, data width in bits (N >= 1).
- DEPTH, 2, number of register stages (DEPTH >= 1).
- CW, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  input  1  rising-edge clock.
- nrst  input  1  asynchronous active-low reset.
- en  input  1  global enable; 0 freezes all state.
- in_valid  input  1  producer has data on in_data.
- in_data  input  N  producer data.
- in_ready  output  1  stage 0 can accept this cycle.
- out_valid  output  1  last stage holds valid data.
- out_data  output  N  last-stage data.
- out_ready  input  1  consumer accepts out_data this cycle.
- count  output  CW  number of valid stages (0..DEPTH).

Behaviour:
- Reset (nrst=0, asynchronous): all stage data = 0, all stage valid = 0. Therefore out_valid=0, out_data=0, count=0. Takes effect immediately, mid-transfer included, and discards in-flight data. Release is synchronous to clk.
- Stage k holds data_k and v_k; stage DEPTH-1 drives out_data and out_valid.
- Ready chain (combinational): rdy_DEPTH = out_ready; rdy_k = ~v_k | rdy_{k+1}. in_ready = en & rdy_0.
- Pop: out_valid & out_ready & en.
- Push: in_valid & in_ready.
- On each clk edge with en=1, for each stage k where rdy_k=1:
  - k = 0: data_0 <= in_data and v_0 <= in_valid.
  - k > 0: data_k <= data_{k-1} and v_k <= v_{k-1}.
  - Stages with rdy_k=0 hold.
- Bubble collapse: an empty stage always accepts from upstream, so gaps close even while the output is stalled.
- Data registers of an invalid stage may load any value; only valid data is guaranteed.
- Latency: DEPTH cycles from push to out_valid when no stall. Throughput: 1 item/cycle with out_ready held at 1.
- Full (count=DEPTH, out_ready=0): in_ready=0 and no state changes. If out_ready=1 while full, a simultaneous push and pop is allowed and count is unchanged.
- Empty (count=0): out_valid=0 and in_ready=en.
- en=0: no register updates, in_ready=0, out_valid forced to 0, out_data still shows the last-stage register, count holds.
- count: registered. It increments on push only, decrements on pop only, and is unchanged on both or neither. It never wraps; the bench asserts count <= DEPTH.
- Ordering: strict FIFO; no duplication or loss.

Optional Feature:
- Macro: REG_PIPE_FLUSH_EN.
- Defined: adds input port flush (1 bit, after out_ready).
  - flush=1 with en=1: in_ready=0 and out_valid=0 that cycle.
  - On the next edge all v_k <= 0 and count <= 0; data registers are unchanged.
  - flush has priority over push and pop.
- Undefined: the flush port does not exist; behaviour is as above.

Test Plan:
- Reset: N=8, DEPTH=3, nrst=0 with en=1 -> out_valid=0, out_data=0x00, count=0, in_ready=1. Pulsing nrst low while count=2 -> count=0 and out_valid=0 immediately, without waiting for a clk edge.
- Streaming: push 0x11, 0x22, 0x33 on consecutive cycles with out_ready=1 -> out_valid rises 3 cycles after the first push, outputs 0x11, 0x22, 0x33 back-to-back, count peaks at 3 then returns to 0.
- Backpressure: out_ready=0, offer 0xA1..0xA5 -> only 0xA1..0xA3 accepted, in_ready=0 after the 3rd, count=3. Then out_ready=1 -> 0xA1 popped and 0xA4 pushed on the same edge, count stays 3, final order 0xA1..0xA5.
- Bubble collapse: out_ready=0, push 0x05, idle 1 cycle, push 0x06 -> in_ready stays 1, count=2, and after 2 more cycles stages DEPTH-1 and DEPTH-2 hold 0x05 and 0x06.
- Enable stall: count=2, en=0 for 4 cycles with in_valid=1 and out_ready=1 -> in_ready=0, out_valid=0, count=2, contents unchanged. After en=1, the original order resumes.
- Flush (REG_PIPE_FLUSH_EN): count=3, flush=1 for one cycle with in_valid=1 -> nothing pushed, next cycle count=0, out_valid=0, in_ready=1.

Source files
------------

// File: rtl/reg_pipe_n.sv
// DEPTH-stage, N-bit valid/ready pipeline register chain with bubble collapse and occupancy count.
// Latency: DEPTH cycles push-to-out_valid when unstalled; 1 item/cycle throughput.
// Backpressure: combinational ready chain, an empty stage always accepts; en=0 freezes everything.
// Optional feature: define REG_PIPE_FLUSH_EN to add a synchronous flush input.
module reg_pipe_n #(
    parameter int N     = 32,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          en,
    input  logic          in_valid,
    input  logic [N-1:0]  in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [N-1:0]  out_data,
    input  logic          out_ready,
`ifdef REG_PIPE_FLUSH_EN
    input  logic          flush,
`endif
    output logic [CW-1:0] count
);

    logic [N-1:0]     stg_dat [DEPTH];
    logic [DEPTH-1:0] stg_vld;
    logic [N-1:0]     src_dat [DEPTH];
    logic [DEPTH-1:0] src_vld;
    logic [DEPTH-1:0] rdy;
    logic             rdy_acc;
    logic [CW-1:0]    cnt;
    logic             do_flush;
    logic             push;
    logic             pop;

`ifdef REG_PIPE_FLUSH_EN
    assign do_flush = en & flush;
`else
    assign do_flush = 1'b0;
`endif

    // rdy_k = ~v_k | rdy_{k+1}, unrolled from the output end as a running OR
    always_comb begin
        rdy_acc = out_ready;
        rdy     = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            rdy_acc = rdy_acc | ~stg_vld[k];
            rdy[k]  = rdy_acc;
        end
    end

    always_comb begin
        src_dat[0] = in_data;
        src_vld    = '0;
        src_vld[0] = in_valid;
        for (int k = 1; k < DEPTH; k++) begin
            src_dat[k] = stg_dat[k-1];
            src_vld[k] = stg_vld[k-1];
        end
    end

    assign in_ready  = en & rdy[0] & ~do_flush;
    assign out_valid = en & stg_vld[DEPTH-1] & ~do_flush;
    assign out_data  = stg_dat[DEPTH-1];
    assign count     = cnt;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int k = 0; k < DEPTH; k++) begin
                stg_dat[k] <= '0;
            end
            stg_vld <= '0;
            cnt     <= '0;
        end else if (en) begin
            if (do_flush) begin
                // valid bits only; stale data in invalid stages is harmless
                stg_vld <= '0;
                cnt     <= '0;
            end else begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (rdy[k]) begin
                        stg_dat[k] <= src_dat[k];
                        stg_vld[k] <= src_vld[k];
                    end
                end
                if (push && !pop) begin
                    cnt <= cnt + CW'(1);
                end else if (pop && !push) begin
                    cnt <= cnt - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_pipe_n.sv
// Scoreboard bench for reg_pipe_n (N=8, DEPTH=3); flush scenario built when REG_PIPE_FLUSH_EN is defined.
module tb_reg_pipe_n;

    localparam int N     = 8;
    localparam int DEPTH = 3;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          nrst;
    logic          en;
    logic          in_valid;
    logic [N-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic [N-1:0]  out_data;
    logic          out_ready;
    logic [CW-1:0] count;
`ifdef REG_PIPE_FLUSH_EN
    logic          flush;
`endif

    int checks = 0;
    int errors = 0;
    logic [N-1:0] sb[$];

    always #5 clk = ~clk;

    reg_pipe_n #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .nrst(nrst), .en(en),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
`ifdef REG_PIPE_FLUSH_EN
        .flush(flush),
`endif
        .count(count)
    );

    // Mid-cycle monitor: inputs are stable here, transfers seen now happen on the next rising edge
    always @(negedge clk) begin
        if (!nrst) begin
            sb.delete();
        end else begin
            checks++;
            if (count !== CW'(sb.size()) || count > CW'(DEPTH)) begin
                errors++;
                $display("FAIL occupancy: count=%0d required=%0d (max %0d)", count, sb.size(), DEPTH);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL order: unexpected output %h, required none", out_data);
                end else begin
                    logic [N-1:0] exp_d;
                    exp_d = sb.pop_front();
                    if (out_data !== exp_d) begin
                        errors++;
                        $display("FAIL order: out_data=%h required=%h", out_data, exp_d);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(in_data);
`ifdef REG_PIPE_FLUSH_EN
            if (flush && en) sb.delete();
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (count == 0) break;
            step();
        end
        checks++;
        if (count !== '0) begin
            errors++;
            $display("FAIL drain: count=%0d required=0 within 20 cycles", count);
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0; en = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef REG_PIPE_FLUSH_EN
        flush = 1'b0;
`endif
        #3;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || count !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: ov=%b od=%h cnt=%0d ir=%b required 0 00 0 1",
                     out_valid, out_data, count, in_ready);
        end
        step();
        nrst = 1'b1;
        in_valid = 1'b1; in_data = 8'hC1;
        step();
        in_data = 8'hC2;
        step();
        in_valid = 1'b0;
        checks++;
        if (count !== CW'(2)) begin
            errors++;
            $display("FAIL reset_prefill: count=%0d required=2", count);
        end
        #1 nrst = 1'b0;
        #1;
        checks++;
        if (count !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: count=%0d ov=%b required 0 0", count, out_valid);
        end
        sb.delete();
        #1 nrst = 1'b1;
        step();
    endtask

    task automatic test_stream();
        logic [N-1:0] vals [3];
        int exp_cnt [7];
        vals = '{8'h11, 8'h22, 8'h33};
        exp_cnt = '{0, 1, 2, 3, 2, 1, 0};
        out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            in_valid = (c < 3);
            in_data  = (c < 3) ? vals[c] : 8'h00;
            #1;
            checks++;
            if (out_valid !== (c >= 3 && c <= 5) || count !== CW'(exp_cnt[c])) begin
                errors++;
                $display("FAIL stream_c%0d: ov=%b cnt=%0d required ov=%b cnt=%0d",
                         c, out_valid, count, (c >= 3 && c <= 5), exp_cnt[c]);
            end
            if (c >= 3 && c <= 5) begin
                checks++;
                if (out_data !== vals[c-3]) begin
                    errors++;
                    $display("FAIL stream_data_c%0d: od=%h required=%h", c, out_data, vals[c-3]);
                end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] vals [5];
        int acc = 0;
        vals = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_data = vals[acc];
            #1;
            checks++;
            if (in_ready !== (acc < 3)) begin
                errors++;
                $display("FAIL bp_ready_c%0d: in_ready=%b required=%b", c, in_ready, (acc < 3));
            end
            if (in_ready) acc++;
            step();
        end
        checks++;
        if (count !== CW'(3)) begin
            errors++;
            $display("FAIL bp_full: count=%0d required=3", count);
        end
        in_data = vals[3]; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'hA1) begin
            errors++;
            $display("FAIL bp_swap: ir=%b ov=%b od=%h required 1 1 a1", in_ready, out_valid, out_data);
        end
        step();
        checks++;
        if (count !== CW'(3)) begin
            errors++;
            $display("FAIL bp_swap_count: count=%0d required=3", count);
        end
        in_data = vals[4];
        step();
        drain();
    endtask

    task automatic test_bubble();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h05;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bubble_rdy0: in_ready=%b required=1", in_ready);
        end
        step();
        in_valid = 1'b0;
        step();
        in_valid = 1'b1; in_data = 8'h06;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bubble_rdy2: in_ready=%b required=1", in_ready);
        end
        step();
        in_valid = 1'b0;
        step();
        step();
        checks++;
        if (count !== CW'(2) || out_valid !== 1'b1 || out_data !== 8'h05) begin
            errors++;
            $display("FAIL bubble_collapse: cnt=%0d ov=%b od=%h required 2 1 05", count, out_valid, out_data);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h06) begin
            errors++;
            $display("FAIL bubble_b2b: ov=%b od=%h required 1 06", out_valid, out_data);
        end
        drain();
    endtask

    task automatic test_enable();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h71;
        step();
        in_data = 8'h72;
        step();
        in_valid = 1'b0;
        step();
        en = 1'b0; in_valid = 1'b1; in_data = 8'h73; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || count !== CW'(2) || out_data !== 8'h71) begin
                errors++;
                $display("FAIL en_stall_c%0d: ir=%b ov=%b cnt=%0d od=%h required 0 0 2 71",
                         c, in_ready, out_valid, count, out_data);
            end
            step();
        end
        in_valid = 1'b0; en = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h71) begin
            errors++;
            $display("FAIL en_resume: ov=%b od=%h required 1 71", out_valid, out_data);
        end
        drain();
    endtask

`ifdef REG_PIPE_FLUSH_EN
    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_data = 8'hB1 + 8'(c);
            step();
        end
        checks++;
        if (count !== CW'(3)) begin
            errors++;
            $display("FAIL flush_fill: count=%0d required=3", count);
        end
        flush = 1'b1; in_data = 8'hB4;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_cycle: ir=%b ov=%b required 0 0", in_ready, out_valid);
        end
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_after: cnt=%0d ov=%b ir=%b required 0 0 1", count, out_valid, in_ready);
        end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_bubble();
        test_enable();
`ifdef REG_PIPE_FLUSH_EN
        test_flush();
`endif
        step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d items never emerged, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
